// File: rtl/spi_sram_master.sv
`timescale 1ns/1ps
// spi_sram_master
// Byte-wide SPI master (mode 0, MSB first) for a serial SRAM-style slave.
// One transfer = SETUP (CLK_DIV) + 8 SCK periods (16*CLK_DIV) + HOLD (CLK_DIV)
// + one DONE cycle. All pin outputs come from flops driven by the current FSM
// state, so they trail the internal state by one clock. That lag is what
// places done 18*CLK_DIV+1 cycles after the accepting edge.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request a transfer (honoured only in IDLE)
//   rw     in   1 = read, 0 = write
//   wdata  in   [7:0] byte to write
//   rdata  out  [7:0] last byte read
//   busy   out  transfer in progress
//   done   out  one-cycle completion pulse
//   cs     out  chip select, active low
//   sck    out  SPI clock, idles low
//   mosi   out  master out
//   miso   in   master in
//   opcode out  [2:0] 0 idle, 2 write, 3 read
module spi_sram_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       cs,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic [2:0] opcode
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_XFER  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_div;       // half-period counter, 0..CLK_DIV-1
    logic       r_phase_lo;  // XFER: 0 = SCK high half, 1 = SCK low half
    logic [2:0] r_bit;       // completed SCK periods, saturates at 7
    logic       r_rw;
    logic [7:0] r_tx;        // outgoing bits; zero for reads so mosi stays 0
    logic [7:0] r_shift;     // incoming bits
    logic [7:0] r_rdata;
    logic       r_busy, r_done, r_cs, r_sck, r_mosi;
    logic [2:0] r_opcode;

    logic       w_div_end, w_active, w_fall;
    logic       w_cs_nxt, w_sck_nxt, w_mosi_nxt;
    logic [2:0] w_op_nxt;

    assign w_div_end = (r_div == DIV_LAST);

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)     w_state_nxt = S_SETUP;
            S_SETUP: if (w_div_end) w_state_nxt = S_XFER;
            S_XFER:  if (w_div_end && r_phase_lo && r_bit == 3'd7)
                                    w_state_nxt = S_HOLD;
            S_HOLD:  if (w_div_end) w_state_nxt = S_DONE;
            S_DONE:                 w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered pins, derived from the current state
    always_comb begin
        w_active   = (r_state == S_SETUP) || (r_state == S_XFER) || (r_state == S_HOLD);
        w_cs_nxt   = ~w_active;
        w_sck_nxt  = (r_state == S_XFER) && !r_phase_lo;
        w_op_nxt   = w_active ? (r_rw ? 3'd3 : 3'd2) : 3'd0;
        // Pin-level falling edge: the slave's shift point and ours.
        w_fall     = r_sck && !w_sck_nxt;
        w_mosi_nxt = 1'b0;
        case (r_state)
            S_SETUP: w_mosi_nxt = r_tx[7];
            S_XFER:  w_mosi_nxt = w_fall ? r_tx[6] : r_mosi;
            default: w_mosi_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_div      <= 8'd0;
            r_phase_lo <= 1'b0;
            r_bit      <= 3'd0;
            r_rw       <= 1'b0;
            r_tx       <= 8'd0;
            r_shift    <= 8'd0;
            r_rdata    <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cs       <= 1'b1;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_opcode   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;

            // Every timed phase ends on w_div_end, so one reset condition suffices.
            if (r_state == S_IDLE || r_state == S_DONE || w_div_end)
                r_div <= 8'd0;
            else
                r_div <= r_div + 8'd1;

            if (r_state == S_XFER) begin
                if (w_div_end) begin
                    r_phase_lo <= ~r_phase_lo;
                    if (r_phase_lo && r_bit != 3'd7)
                        r_bit <= r_bit + 3'd1;
                end
            end else begin
                r_phase_lo <= 1'b0;
                r_bit      <= 3'd0;
            end

            if (r_state == S_IDLE && start) begin
                r_rw <= rw;
                r_tx <= rw ? 8'd0 : wdata;
            end else if (w_fall) begin
                r_tx <= {r_tx[6:0], 1'b0};
                if (r_rw)
                    r_shift <= {r_shift[6:0], miso};
            end

            if (r_state == S_DONE && r_rw)
                r_rdata <= r_shift;

            r_busy   <= (r_state != S_IDLE);
            r_done   <= (r_state == S_DONE);
            r_cs     <= w_cs_nxt;
            r_sck    <= w_sck_nxt;
            r_mosi   <= w_mosi_nxt;
            r_opcode <= w_op_nxt;
        end
    end

    assign rdata  = r_rdata;
    assign busy   = r_busy;
    assign done   = r_done;
    assign cs     = r_cs;
    assign sck    = r_sck;
    assign mosi   = r_mosi;
    assign opcode = r_opcode;

endmodule
